// File: rtl/up_counter_tff_pkg.sv
// up_counter_tff_pkg
//   Shared definitions for the T flip-flop counter family (up and down
//   counters). Holds the count width, the default modulus, the reset level
//   and the per-edge operation decode used by the next-state logic.
package up_counter_tff_pkg;

  localparam int       CNT_W       = 4;
  localparam int       MOD_DEFAULT = 16;
  localparam logic     RST_ACTIVE  = 1'b0;

  // Operation selected on a rising edge once reset is not active.
  typedef enum logic [1:0] {
    OP_HOLD  = 2'd0,
    OP_COUNT = 2'd1,
    OP_LOAD  = 2'd2
  } cnt_op_e;

  // Load outranks count; count outranks hold.
  function automatic cnt_op_e op_decode(input logic load, input logic en);
    cnt_op_e op;
    if (load) begin
      op = OP_LOAD;
    end else if (en) begin
      op = OP_COUNT;
    end else begin
      op = OP_HOLD;
    end
    return op;
  endfunction

endpackage

// File: rtl/up_counter_tff_t_ff.sv
// t_ff
//   Single T flip-flop with synchronous clear.
//   clk : rising-edge clock
//   rst : synchronous clear, active at RST_ACTIVE (low)
//   t   : toggle request
//   q   : stored bit
module t_ff
  import up_counter_tff_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic t,
  output logic q
);

  // Clear wins over toggle; otherwise toggle when t is high.
  always_ff @(posedge clk) begin
    if (rst == RST_ACTIVE) begin
      q <= 1'b0;
    end else if (t) begin
      q <= ~q;
    end else begin
      q <= q;
    end
  end

endmodule

// File: rtl/up_counter_tff.sv
// up_counter_tff
//   Synchronous modulo-MOD up counter built from four T flip-flops.
//   Pin-compatible with the T-FF down counter (individual bit outputs).
//   The modulus parameter is legal from 2 to 16; the count wraps MOD-1 -> 0.
//   clk  : rising-edge clock
//   rst  : synchronous active-low reset (highest priority)
//   en   : count enable
//   load : parallel load strobe (beats en)
//   d    : load value; values >= MOD load 0
//   Q4..Q1 : count bits, Q4 is MSB, straight from flip-flops
//   tc   : terminal count, en AND (count == MOD-1), combinational
module up_counter_tff
  import up_counter_tff_pkg::*;
#(
  parameter int MOD = MOD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             load,
  input  logic [CNT_W-1:0] d,
  output logic             Q4,
  output logic             Q3,
  output logic             Q2,
  output logic             Q1,
  output logic             tc
);

  localparam logic [CNT_W-1:0] MOD_MAX = CNT_W'(MOD - 1);

  logic [CNT_W-1:0] c_s;
  logic [CNT_W-1:0] next_c_s;
  logic [CNT_W-1:0] t_s;
  cnt_op_e          op_s;

  // Next count value; reset is not handled here, it clears inside each T-FF.
  always_comb begin
    next_c_s = c_s;
    op_s     = op_decode(load, en);
    case (op_s)
      OP_LOAD: begin
        if (d <= MOD_MAX) begin
          next_c_s = d;
        end else begin
          next_c_s = '0;
        end
      end
      OP_COUNT: begin
        // >= also sends any out-of-range code back to 0.
        if (c_s >= MOD_MAX) begin
          next_c_s = '0;
        end else begin
          next_c_s = c_s + 4'd1;
        end
      end
      OP_HOLD: begin
        next_c_s = c_s;
      end
      default: begin
        next_c_s = '0;
      end
    endcase
  end

  // A bit toggles exactly where the next count differs from the current one;
  // for MOD=16 without load this collapses to the classic en & carry chain.
  assign t_s = c_s ^ next_c_s;

  genvar i;
  generate
    for (i = 0; i < CNT_W; i++) begin : g_bit
      t_ff u_t_ff (
        .clk (clk),
        .rst (rst),
        .t   (t_s[i]),
        .q   (c_s[i])
      );
    end
  endgenerate

  assign Q4 = c_s[3];
  assign Q3 = c_s[2];
  assign Q2 = c_s[1];
  assign Q1 = c_s[0];

  // Cascade enable for the next stage; deliberately not gated by load.
  assign tc = en & (c_s == MOD_MAX);

endmodule

// File: tb/tb_up_counter_tff.sv
// tb_up_counter_tff
//   Drives a MOD=16 and a MOD=10 instance with shared stimulus. Expected
//   counts from a reference model are queued when stimulus is applied and
//   compared after the following rising edge; tc is compared before the edge.
module tb_up_counter_tff;

  logic       clk;
  logic       rst;
  logic       en;
  logic       load;
  logic [3:0] d;

  logic q4_16, q3_16, q2_16, q1_16, tc_16;
  logic q4_10, q3_10, q2_10, q1_10, tc_10;

  int n_checks;
  int n_errors;

  logic [3:0] exp_q16[$];
  logic [3:0] exp_q10[$];

  int  m16_c;
  int  m10_c;
  bit  model_valid;

  up_counter_tff #(.MOD(16)) u_dut16 (
    .clk(clk), .rst(rst), .en(en), .load(load), .d(d),
    .Q4(q4_16), .Q3(q3_16), .Q2(q2_16), .Q1(q1_16), .tc(tc_16)
  );

  up_counter_tff #(.MOD(10)) u_dut10 (
    .clk(clk), .rst(rst), .en(en), .load(load), .d(d),
    .Q4(q4_10), .Q3(q3_10), .Q2(q2_10), .Q1(q1_10), .tc(tc_10)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
    end
  endtask

  // Reference next-state from the counter's behavioural rules.
  function automatic int model_next(input int c, input int m, input bit r,
                                    input bit e, input bit l, input int dv);
    if (!r) return 0;
    if (l) return (dv <= m - 1) ? dv : 0;
    if (e) return (c >= m - 1) ? 0 : c + 1;
    return c;
  endfunction

  // One clock: apply inputs (at negedge), check tc, queue expectation, check count.
  task automatic step(input bit r, input bit e, input bit l, input logic [3:0] dv);
    logic [3:0] got;
    rst  = r;
    en   = e;
    load = l;
    d    = dv;
    #1;
    if (model_valid) begin
      check("tc16", {3'b000, tc_16}, {3'b000, (e && m16_c == 15)});
      check("tc10", {3'b000, tc_10}, {3'b000, (e && m10_c == 9)});
    end
    m16_c = model_next(m16_c, 16, r, e, l, int'(dv));
    m10_c = model_next(m10_c, 10, r, e, l, int'(dv));
    exp_q16.push_back(4'(m16_c));
    exp_q10.push_back(4'(m10_c));
    model_valid = 1'b1;
    @(posedge clk);
    #1;
    if (exp_q16.size() == 0 || exp_q10.size() == 0) begin
      check("queue_empty", 4'd1, 4'd0);
    end else begin
      got = {q4_16, q3_16, q2_16, q1_16};
      check("cnt16", got, exp_q16.pop_front());
      got = {q4_10, q3_10, q2_10, q1_10};
      check("cnt10", got, exp_q10.pop_front());
    end
    @(negedge clk);
  endtask

  initial begin
    n_checks    = 0;
    n_errors    = 0;
    m16_c       = 0;
    m10_c       = 0;
    model_valid = 1'b0;
    rst  = 1'b0;
    en   = 1'b1;
    load = 1'b0;
    d    = 4'd0;
    @(negedge clk);

    // Reset for two edges with en high, then count through a full MOD-16 wrap.
    step(1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 18; i++) step(1'b1, 1'b1, 1'b0, 4'd0);

    // Back to 0, count to 5, hold three cycles, load 7, resume.
    step(1'b0, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) step(1'b1, 1'b1, 1'b0, 4'd0);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b1, 4'd7);
    step(1'b1, 1'b1, 1'b0, 4'd0);
    step(1'b1, 1'b1, 1'b0, 4'd0);

    // Out-of-range load (12), then load 9 so MOD-10 shows tc next cycle.
    step(1'b1, 1'b0, 1'b1, 4'd12);
    step(1'b1, 1'b1, 1'b1, 4'd9);
    // Load while tc is active on MOD-10: load wins, tc still reported.
    step(1'b1, 1'b1, 1'b1, 4'd3);
    step(1'b1, 1'b1, 1'b1, 4'd15);

    // Reset beats a simultaneous load, and holds 0 while asserted.
    step(1'b1, 1'b0, 1'b1, 4'd6);
    step(1'b0, 1'b1, 1'b1, 4'd3);
    step(1'b0, 1'b1, 1'b0, 4'd0);
    step(1'b0, 1'b1, 1'b0, 4'd0);

    // Random mix, reset kept rare.
    for (int i = 0; i < 60; i++) begin
      step(($urandom_range(0, 15) != 0), $urandom_range(0, 3) != 0,
           $urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
